// File: rtl/adc_wave_capture.sv
// Captures a fixed-length ADC or FIR record into RAM on an active-low request strobe and
// streams it as bytes over valid/ready. Define ADC_WAVE_CAPTURE_CHECKSUM_EN to append an XOR trailer byte.
module adc_wave_capture #(
    parameter int          SAMPLE_W   = 12,
    parameter int          FIR_W      = 16,
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                acquireWave,
    input  logic                acquireFIR,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    input  logic [FIR_W-1:0]    fir_data,
    input  logic                fir_valid,
    input  logic                tx_ready,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    output logic [15:0]         wavenum,
    output logic                busy
);
    localparam logic [DEPTH_LOG2-1:0] LAST = '1;
    localparam logic [DEPTH_LOG2-1:0] ONE  = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        IDLE, CAPTURE, SEND_HDR, SEND_DATA,
`ifdef ADC_WAVE_CAPTURE_CHECKSUM_EN
        SEND_CKSUM,
`endif
        DONE
    } state_t;

    state_t                 state;
    logic                   src;
    logic                   wave_q, fir_q;
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr, rd_next;
    logic                   lo, last_smp, hdr_ph;
    logic                   xfer, sel_valid;
    logic [15:0]            sel_data, ram_q;
    logic [15:0]            ram [2**DEPTH_LOG2];
`ifdef ADC_WAVE_CAPTURE_CHECKSUM_EN
    logic [7:0]             cksum;
`endif

    always_comb begin
        xfer      = tx_valid && tx_ready;
        sel_valid = src ? fir_valid : adc_valid;
        sel_data  = src ? 16'(fir_data) : 16'(adc_data);
        // Read address runs one step ahead so the next sample is in ram_q when its MSB is due.
        rd_next   = rd_ptr;
        if (state == IDLE || state == CAPTURE)
            rd_next = '0;
        else if (state == SEND_DATA && xfer && !lo && rd_ptr != LAST)
            rd_next = rd_ptr + ONE;
    end

    always_ff @(posedge clk) begin
        if (state == CAPTURE && sel_valid)
            ram[wr_ptr] <= sel_data;
        ram_q <= ram[rd_next];
    end

    always_ff @(posedge clk) begin
        wave_q <= acquireWave;
        fir_q  <= acquireFIR;
        if (reset) begin
            state    <= IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            wavenum  <= 16'h0000;
            busy     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            src      <= 1'b0;
            lo       <= 1'b0;
            last_smp <= 1'b0;
            hdr_ph   <= 1'b0;
`ifdef ADC_WAVE_CAPTURE_CHECKSUM_EN
            cksum    <= 8'h00;
`endif
        end else begin
            rd_ptr <= rd_next;
            case (state)
                IDLE: begin
                    busy   <= 1'b0;
                    wr_ptr <= '0;
                    if (wave_q && !acquireWave) begin
                        src   <= 1'b0;
                        busy  <= 1'b1;
                        state <= CAPTURE;
                    end else if (fir_q && !acquireFIR) begin
                        src   <= 1'b1;
                        busy  <= 1'b1;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: if (sel_valid) begin
                    wr_ptr <= wr_ptr + ONE;
                    if (wr_ptr == LAST) begin
                        tx_data  <= HDR_BYTE;
                        tx_valid <= 1'b1;
                        hdr_ph   <= 1'b0;
                        state    <= SEND_HDR;
                    end
                end
                SEND_HDR: if (xfer) begin
                    if (!hdr_ph) begin
                        tx_data <= src ? 8'h69 : 8'h77;
                        hdr_ph  <= 1'b1;
                    end else begin
                        tx_data <= ram_q[15:8];
                        lo      <= 1'b0;
                        state   <= SEND_DATA;
`ifdef ADC_WAVE_CAPTURE_CHECKSUM_EN
                        cksum   <= tx_data;
`endif
                    end
                end
                SEND_DATA: if (xfer) begin
`ifdef ADC_WAVE_CAPTURE_CHECKSUM_EN
                    cksum <= cksum ^ tx_data;
`endif
                    if (!lo) begin
                        tx_data  <= ram_q[7:0];
                        lo       <= 1'b1;
                        last_smp <= (rd_ptr == LAST);
                    end else if (!last_smp) begin
                        tx_data <= ram_q[15:8];
                        lo      <= 1'b0;
                    end else begin
`ifdef ADC_WAVE_CAPTURE_CHECKSUM_EN
                        tx_data <= cksum ^ tx_data;
                        state   <= SEND_CKSUM;
`else
                        tx_valid <= 1'b0;
                        state    <= DONE;
`endif
                    end
                end
`ifdef ADC_WAVE_CAPTURE_CHECKSUM_EN
                SEND_CKSUM: if (xfer) begin
                    tx_valid <= 1'b0;
                    state    <= DONE;
                end
`endif
                DONE: begin
                    wavenum <= wavenum + 16'd1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_wave_capture.sv
// Scoreboard bench for adc_wave_capture with a 4-sample record: expected bytes are queued
// when a capture is driven and popped as the DUT transfers them.
module tb_adc_wave_capture;
    localparam int D = 2;
    localparam int N = 4;

    logic        clk = 1'b0, reset = 1'b1;
    logic        acquireWave = 1'b1, acquireFIR = 1'b1;
    logic [11:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic [15:0] fir_data = '0;
    logic        fir_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [15:0] wavenum;
    logic        busy;

    int          errors = 0, checks = 0, nbytes = 0;
    logic [7:0]  expq [$];
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [15:0] smp [N];

    adc_wave_capture #(.SAMPLE_W(12), .FIR_W(16), .DEPTH_LOG2(D), .HDR_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .acquireWave(acquireWave), .acquireFIR(acquireFIR),
        .adc_data(adc_data), .adc_valid(adc_valid), .fir_data(fir_data), .fir_valid(fir_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .wavenum(wavenum), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe at negedge, then return just after the posedge so inputs can change.
    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        if (!reset) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                nbytes++;
                if (expq.size() == 0) chk("unexpected_byte", 32'(tx_data), 32'h100);
                else begin
                    e = expq.pop_front();
                    chk("tx_byte", 32'(tx_data), 32'(e));
                end
            end
        end
        prev_stall = !reset && tx_valid && !tx_ready;
        prev_data  = tx_data;
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input logic fir, input logic [15:0] s [N]);
        logic [7:0] ck, b;
        expq.push_back(8'hA5);
        b = fir ? 8'h69 : 8'h77;
        expq.push_back(b);
        ck = b;
        for (int i = 0; i < N; i++) begin
            expq.push_back(s[i][15:8]);
            expq.push_back(s[i][7:0]);
            ck = ck ^ s[i][15:8] ^ s[i][7:0];
        end
`ifdef ADC_WAVE_CAPTURE_CHECKSUM_EN
        expq.push_back(ck);
`endif
    endtask

    // both=1: both strobes fall together, FIR falls again mid-capture, wave held low throughout.
    task automatic capture(input logic fir, input logic both, input logic [15:0] s [N]);
        int i = 0, c = 0;
        if (fir) acquireFIR = 1'b0;
        else begin
            acquireWave = 1'b0;
            if (both) acquireFIR = 1'b0;
        end
        step();
        chk("busy_on_request", 32'(busy), 32'd1);
        if (!both) begin
            acquireWave = 1'b1;
            acquireFIR  = 1'b1;
        end
        while (i < N && c < 200) begin
            c++;
            if (both && i == 0) acquireFIR = 1'b1;
            if (both && i == 2) acquireFIR = 1'b0;
            if (fir) begin
                adc_valid = c[0];
                adc_data  = 12'($urandom);
                fir_valid = (c % 3 == 0);
                fir_data  = s[i];
            end else begin
                fir_valid = c[0];
                fir_data  = 16'($urandom);
                adc_valid = 1'b1;
                adc_data  = s[i][11:0];
            end
            step();
            if ((fir && fir_valid) || (!fir && adc_valid)) i++;
        end
        adc_valid = 1'b0;
        fir_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, input bit rnd);
        int n = 0;
        while (busy && n < max) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("record_done_in_time", 32'(busy), 32'd0);
        tx_ready = 1'b1;
        chk("queue_drained", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        int base, n;
        repeat (3) step();
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_wavenum", 32'(wavenum), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        step();

        // Raw ADC ramp, no stalls
        smp = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        push_rec(1'b0, smp);
        capture(1'b0, 1'b0, smp);
        wait_idle(200, 1'b0);
        chk("wavenum_ramp", 32'(wavenum), 32'd1);

        // FIR every 3rd cycle while the ADC stream toggles
        smp = '{16'h8001, 16'h8002, 16'h8003, 16'h8004};
        push_rec(1'b1, smp);
        capture(1'b1, 1'b0, smp);
        wait_idle(200, 1'b0);
        chk("wavenum_fir", 32'(wavenum), 32'd2);

        // Header held under 5 cycles of backpressure, then random ready
        smp = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        tx_ready = 1'b0;
        push_rec(1'b0, smp);
        capture(1'b0, 1'b0, smp);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_hdr", 32'(tx_data), 32'hA5);
            step();
        end
        wait_idle(400, 1'b1);
        chk("wavenum_stall", 32'(wavenum), 32'd3);

        // Simultaneous falls choose wave; second FIR fall and held levels are ignored
        push_rec(1'b0, smp);
        capture(1'b0, 1'b1, smp);
        wait_idle(200, 1'b0);
        for (int k = 0; k < 10; k++) step();
        chk("no_retrigger", 32'(busy), 32'd0);
        acquireWave = 1'b1;
        acquireFIR  = 1'b1;
        step();
        chk("wavenum_both", 32'(wavenum), 32'd4);

        // Reset in the middle of the data bytes
        smp = '{16'(12'($urandom)), 16'(12'($urandom)), 16'(12'($urandom)), 16'(12'($urandom))};
        push_rec(1'b0, smp);
        capture(1'b0, 1'b0, smp);
        base = nbytes;
        n = 0;
        while (nbytes < base + 4 && n < 50) begin step(); n++; end
        chk("reached_data_phase", 32'(nbytes - base), 32'd4);
        reset = 1'b1;
        step();
        chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_wavenum", 32'(wavenum), 32'd0);
        reset = 1'b0;
        expq.delete();
        step();
        smp = '{16'h0ABC, 16'h0123, 16'h0FFF, 16'h0000};
        push_rec(1'b0, smp);
        capture(1'b0, 1'b0, smp);
        wait_idle(200, 1'b1);
        chk("wavenum_after_reset", 32'(wavenum), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
